// File: rtl/dmem_arbiter.sv
// Round-robin arbiter/sequencer for the shared 256-bit line data memory.
// state | meaning: IDLE wait for request, ISSUE pulse mem enable, WAIT await mem ack, RESP ack requester
module dmem_arbiter #(
   parameter int ADDR_W = 32,
   parameter int LINE_W = 256
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              req0_enable_i,
   input  logic              req0_write_i,
   input  logic [ADDR_W-1:0] req0_addr_i,
   input  logic [LINE_W-1:0] req0_data_i,
   output logic              req0_ack_o,
   output logic [LINE_W-1:0] req0_data_o,
   input  logic              req1_enable_i,
   input  logic              req1_write_i,
   input  logic [ADDR_W-1:0] req1_addr_i,
   input  logic [LINE_W-1:0] req1_data_i,
   output logic              req1_ack_o,
   output logic [LINE_W-1:0] req1_data_o,
   output logic              mem_enable_o,
   output logic              mem_write_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [LINE_W-1:0] mem_data_o,
   input  logic              mem_ack_i,
   input  logic [LINE_W-1:0] mem_data_i,
   output logic              grant_o,
   output logic              busy_o
);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

   state_t              state_q;
   logic                last_grant_q;
   logic                grant_q;
   logic                ack0_q;
   logic                ack1_q;
   logic                mem_en_q;
   logic                mem_wr_q;
   logic [ADDR_W-1:0]   mem_addr_q;
   logic [LINE_W-1:0]   mem_data_q;
   logic                pick_d;

   // On a tie the port that did not win last time goes next.
   always_comb begin
      pick_d = 1'b0;
      if (req0_enable_i && req1_enable_i) pick_d = ~last_grant_q;
      else if (req1_enable_i)             pick_d = 1'b1;
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q      <= S_IDLE;
         last_grant_q <= 1'b1;
         grant_q      <= 1'b0;
         ack0_q       <= 1'b0;
         ack1_q       <= 1'b0;
         mem_en_q     <= 1'b0;
         mem_wr_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_data_q   <= '0;
      end else begin
         mem_en_q <= 1'b0;
         ack0_q   <= 1'b0;
         ack1_q   <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (req0_enable_i || req1_enable_i) begin
                  grant_q      <= pick_d;
                  last_grant_q <= pick_d;
                  mem_addr_q   <= pick_d ? req1_addr_i  : req0_addr_i;
                  mem_data_q   <= pick_d ? req1_data_i  : req0_data_i;
                  mem_wr_q     <= pick_d ? req1_write_i : req0_write_i;
                  mem_en_q     <= 1'b1;
                  state_q      <= S_ISSUE;
               end
            end
            S_ISSUE: state_q <= S_WAIT;
            S_WAIT: begin
               if (mem_ack_i) begin
                  ack0_q  <= ~grant_q;
                  ack1_q  <= grant_q;
                  state_q <= S_RESP;
               end
            end
            S_RESP:  state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign req0_ack_o   = ack0_q;
   assign req1_ack_o   = ack1_q;
   assign req0_data_o  = mem_data_i;
   assign req1_data_o  = mem_data_i;
   assign mem_enable_o = mem_en_q;
   assign mem_write_o  = mem_wr_q;
   assign mem_addr_o   = mem_addr_q;
   assign mem_data_o   = mem_data_q;
   assign grant_o      = grant_q;
   assign busy_o       = (state_q != S_IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: two requester drivers, a 10-cycle memory, and a
// transaction-level timing/data model of the arbiter.
module tb_dmem_arbiter;
   localparam int AW = 32;
   localparam int LW = 256;

   typedef struct {
      logic          w;
      logic [AW-1:0] a;
      logic [LW-1:0] d;
   } txn_t;

   logic          clk_i = 1'b0;
   logic          rst_i = 1'b0;
   logic          req0_enable_i, req0_write_i, req1_enable_i, req1_write_i;
   logic [AW-1:0] req0_addr_i, req1_addr_i, mem_addr_o;
   logic [LW-1:0] req0_data_i, req1_data_i, req0_data_o, req1_data_o;
   logic [LW-1:0] mem_data_o;
   logic          req0_ack_o, req1_ack_o, mem_enable_o, mem_write_o;
   logic          grant_o, busy_o;
   logic          mem_ack_i = 1'b0;
   logic [LW-1:0] mem_data_i = '0;

   logic          en [2];
   logic          wr [2];
   logic [AW-1:0] ad [2];
   logic [LW-1:0] dt [2];
   txn_t          qp [2][$];

   assign req0_enable_i = en[0];
   assign req0_write_i  = wr[0];
   assign req0_addr_i   = ad[0];
   assign req0_data_i   = dt[0];
   assign req1_enable_i = en[1];
   assign req1_write_i  = wr[1];
   assign req1_addr_i   = ad[1];
   assign req1_data_i   = dt[1];

   always #5 clk_i = ~clk_i;

   dmem_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .req0_enable_i(req0_enable_i), .req0_write_i(req0_write_i),
      .req0_addr_i(req0_addr_i), .req0_data_i(req0_data_i),
      .req0_ack_o(req0_ack_o), .req0_data_o(req0_data_o),
      .req1_enable_i(req1_enable_i), .req1_write_i(req1_write_i),
      .req1_addr_i(req1_addr_i), .req1_data_i(req1_data_i),
      .req1_ack_o(req1_ack_o), .req1_data_o(req1_data_o),
      .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o),
      .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
      .mem_ack_i(mem_ack_i), .mem_data_i(mem_data_i),
      .grant_o(grant_o), .busy_o(busy_o)
   );

   int n_vec = 0;
   int n_bad = 0;
   int cyc   = 0;

   // memory device
   logic [LW-1:0] sim_mem [512];
   logic [LW-1:0] ref_mem [512];
   int            mcnt = 0;
   bit            en_seen = 0, rd_pend = 0, mw = 0;
   logic [8:0]    mline = '0;
   logic [LW-1:0] mdata = '0, rd_line = '0;

   // transaction model
   bit            m_act = 0, m_last = 1, m_grant = 0, x_port = 0, x_wr = 0;
   int            m_s = 0;
   logic [AW-1:0] x_addr = '0;
   logic [LW-1:0] x_data = '0, x_rdata = '0;

   // driver / reset control
   bit            drop [2];
   int            gap [2];
   bit            rnd_gap = 0, abort_arm = 0;
   int            rst_hold = 0;

   task automatic check_val(string tag, logic [LW-1:0] obs, logic [LW-1:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic logic [LW-1:0] rnd_line();
      logic [LW-1:0] l;
      for (int i = 0; i < LW/32; i++) l[i*32 +: 32] = $urandom;
      return l;
   endfunction

   function automatic txn_t mk(logic w, logic [AW-1:0] a, logic [LW-1:0] d);
      txn_t t;
      t.w = w; t.a = a; t.d = d;
      return t;
   endfunction

   task automatic step();
      txn_t t;
      bit   exp_busy, exp_en, exp_ack0, exp_ack1, was_act;
      @(posedge clk_i); #1;
      cyc++;
      if (rst_hold > 0) begin
         rst_hold--;
         if (rst_hold == 0) rst_i = 1'b1;
      end else if (abort_arm && m_act && cyc == m_s + 6) begin
         rst_i     = 1'b0;
         rst_hold  = 2;
         abort_arm = 0;
      end
      // memory: ack 10 cycles after it samples enable, read line one cycle later
      mem_ack_i  = 1'b0;
      mem_data_i = rd_pend ? rd_line : '0;
      rd_pend    = 0;
      if (!rst_i) begin
         mcnt = 0; en_seen = 0;
      end else begin
         if (mcnt > 0) begin
            mcnt--;
            if (mcnt == 0) begin
               mem_ack_i = 1'b1;
               if (mw) sim_mem[mline] = mdata;
               else begin rd_line = sim_mem[mline]; rd_pend = 1; end
            end
         end
         if (en_seen) begin mcnt = 10; en_seen = 0; end
      end
      for (int p = 0; p < 2; p++) begin
         if (!rst_i) begin
            en[p] = 1'b0; drop[p] = 0; gap[p] = 0;
         end else if (drop[p]) begin
            en[p] = 1'b0; drop[p] = 0;
            gap[p] = rnd_gap ? int'($urandom_range(0, 20)) : 0;
         end else if (!en[p]) begin
            if (gap[p] > 0) gap[p]--;
            else if (qp[p].size() > 0) begin
               t = qp[p].pop_front();
               en[p] = 1'b1; wr[p] = t.w; ad[p] = t.a; dt[p] = t.d;
            end
         end else if (m_act && int'(x_port) == p && cyc == m_s + 5) begin
            ad[p] = $urandom; dt[p] = rnd_line(); wr[p] = ~wr[p];
         end
      end

      @(negedge clk_i);
      if (!rst_i) begin
         m_act = 0; m_last = 1; m_grant = 0;
         x_addr = '0; x_data = '0; x_wr = 0;
      end
      exp_busy = m_act && cyc > m_s;
      exp_en   = m_act && cyc == m_s + 1;
      exp_ack0 = m_act && cyc == m_s + 13 && !x_port;
      exp_ack1 = m_act && cyc == m_s + 13 && x_port;
      check_val("busy",     LW'(busy_o),       LW'(exp_busy));
      check_val("mem_en",   LW'(mem_enable_o), LW'(exp_en));
      check_val("ack0",     LW'(req0_ack_o),   LW'(exp_ack0));
      check_val("ack1",     LW'(req1_ack_o),   LW'(exp_ack1));
      check_val("grant",    LW'(grant_o),      LW'(m_grant));
      check_val("mem_addr", LW'(mem_addr_o),   LW'(x_addr));
      check_val("mem_data", mem_data_o,        x_data);
      check_val("mem_wr",   LW'(mem_write_o),  LW'(x_wr));
      if (exp_ack0 && !x_wr) check_val("rdata0", req0_data_o, x_rdata);
      if (exp_ack1 && !x_wr) check_val("rdata1", req1_data_o, x_rdata);
      was_act = m_act;
      if (m_act && cyc == m_s + 13) begin
         if (x_wr) ref_mem[x_addr[13:5]] = x_data;
         m_act = 0;
      end
      if (rst_i && !was_act && (en[0] || en[1])) begin
         x_port  = (en[0] && en[1]) ? !m_last : en[1];
         m_act   = 1;
         m_s     = cyc;
         m_last  = x_port;
         m_grant = x_port;
         x_addr  = ad[x_port];
         x_data  = dt[x_port];
         x_wr    = wr[x_port];
         x_rdata = ref_mem[ad[x_port][13:5]];
      end
      if (rst_i && mem_enable_o) begin
         en_seen = 1; mw = mem_write_o; mline = mem_addr_o[13:5]; mdata = mem_data_o;
      end
      if (req0_ack_o) drop[0] = 1;
      if (req1_ack_o) drop[1] = 1;
   endtask

   task automatic run_until_idle(int budget);
      int n = 0;
      do begin
         step();
         n++;
      end while ((qp[0].size() > 0 || qp[1].size() > 0 || en[0] || en[1] || m_act || rst_hold > 0)
                 && n < budget);
      check_val("drain", LW'(qp[0].size() + qp[1].size() + int'(en[0]) + int'(en[1]) + int'(m_act)), '0);
   endtask

   task automatic do_reset();
      rst_i = 1'b0;
      step();
      step();
      rst_i = 1'b1;
   endtask

   initial begin
      for (int p = 0; p < 2; p++) begin
         en[p] = 1'b0; wr[p] = 1'b0; ad[p] = '0; dt[p] = '0; drop[p] = 0; gap[p] = 0;
      end
      for (int i = 0; i < 512; i++) begin
         sim_mem[i] = rnd_line();
         ref_mem[i] = sim_mem[i];
      end
      sim_mem[2] = {32{8'hA5}};
      ref_mem[2] = {32{8'hA5}};

      do_reset();
      // single read on port 0
      qp[0].push_back(mk(1'b0, 32'h0000_0040, '0));
      run_until_idle(100);
      // write then read on port 1
      qp[1].push_back(mk(1'b1, 32'h0000_0100, {8{32'h1234_5678}}));
      qp[1].push_back(mk(1'b0, 32'h0000_0100, '0));
      run_until_idle(100);
      // simultaneous from reset, then continuous contention (6 transactions)
      do_reset();
      for (int k = 0; k < 3; k++) begin
         qp[0].push_back(mk(1'b0, AW'(32'h0000_0020 * (k + 1)), '0));
         qp[1].push_back(mk(1'b0, AW'(32'h0000_0100 + 32'h20 * k), '0));
      end
      run_until_idle(200);
      // write whose inputs get scrambled mid-flight, then read back
      qp[0].push_back(mk(1'b1, 32'h0000_01E0, {8{32'hC0DE_F00D}}));
      qp[0].push_back(mk(1'b0, 32'h0000_01E0, '0));
      run_until_idle(100);
      // reset during WAIT aborts a write; a later read sees the old line
      abort_arm = 1;
      qp[0].push_back(mk(1'b1, 32'h0000_0060, {8{32'hDEAD_BEEF}}));
      run_until_idle(100);
      qp[0].push_back(mk(1'b0, 32'h0000_0060, '0));
      run_until_idle(100);
      // randomized traffic on both ports
      rnd_gap = 1;
      for (int k = 0; k < 40; k++) begin
         for (int p = 0; p < 2; p++)
            qp[p].push_back(mk(1'($urandom_range(0, 1)),
                               (AW'($urandom_range(0, 15)) << 5) | AW'($urandom_range(0, 31)),
                               rnd_line()));
      end
      run_until_idle(20000);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
